// File: rtl/load_tid_tracker.sv
// Purpose : tracks outstanding dcache loads; grants a TID per load, stores its payload,
//           and returns the payload when the memory response for that TID arrives.
// Latency : grant is combinational; response -> rsp_valid_o/err_o is 1 cycle (registered).
// Backpr. : alloc_ready_o drops when every entry is occupied or flush_i is high; responses are never stalled.
// Optional: LOAD_TID_KILL_STATS_EN enables the saturating killed-response counter on kill_cnt_o.
// Ports   : clk_i/rst_i (sync, active-high); alloc_valid_i/alloc_ready_o/alloc_payload_i/alloc_tid_o
//           allocation handshake; rsp_valid_i/rsp_tid_i memory response; flush_i kills outstanding
//           loads; rsp_valid_o/rsp_tid_o/rsp_payload_o forwarded response; err_o bad-TID pulse;
//           empty_o/count_o occupancy; kill_cnt_o killed-response count.
module load_tid_tracker #(
  parameter int  NR_ENTRIES    = 2,
  parameter int  TID_WIDTH     = 2,
  parameter int  PAYLOAD_WIDTH = 8,
  localparam int CNT_W         = $clog2(NR_ENTRIES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alloc_valid_i,
  output logic                     alloc_ready_o,
  input  logic [PAYLOAD_WIDTH-1:0] alloc_payload_i,
  output logic [TID_WIDTH-1:0]     alloc_tid_o,
  input  logic                     rsp_valid_i,
  input  logic [TID_WIDTH-1:0]     rsp_tid_i,
  input  logic                     flush_i,
  output logic                     rsp_valid_o,
  output logic [TID_WIDTH-1:0]     rsp_tid_o,
  output logic [PAYLOAD_WIDTH-1:0] rsp_payload_o,
  output logic                     err_o,
  output logic                     empty_o,
  output logic [CNT_W-1:0]         count_o,
  output logic [15:0]              kill_cnt_o
);

  // occ=0 -> FREE; occ=1,killed=0 -> LIVE; occ=1,killed=1 -> KILLED.
  typedef struct packed {
    logic                     occ;
    logic                     killed;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } entry_t;

  entry_t [NR_ENTRIES-1:0] ent_q, ent_d;

  logic                     grant_found;
  logic [TID_WIDTH-1:0]     grant_tid;
  logic                     alloc_fire;
  logic [NR_ENTRIES-1:0]    rsp_hit;     // response addresses an occupied entry
  logic                     live_hit;
  logic [TID_WIDTH-1:0]     fwd_tid;
  logic [PAYLOAD_WIDTH-1:0] fwd_payload;
  logic                     err_d;
  logic [CNT_W-1:0]         cnt;

  logic                     rsp_valid_q;
  logic [TID_WIDTH-1:0]     rsp_tid_q;
  logic [PAYLOAD_WIDTH-1:0] rsp_payload_q;
  logic                     err_q;

  // Lowest-index free entry, from registered occupancy only. An entry freed by
  // a response this cycle is still seen as occupied, so it is grantable next cycle.
  always_comb begin
    grant_found = 1'b0;
    grant_tid   = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].occ) begin
        grant_found = 1'b1;
        grant_tid   = TID_WIDTH'(i);
      end
    end
  end

  assign alloc_ready_o = grant_found && !flush_i;
  assign alloc_tid_o   = grant_tid;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      rsp_hit[i] = rsp_valid_i && (rsp_tid_i == TID_WIDTH'(i)) && ent_q[i].occ;
    end
  end

  // Out-of-range TIDs never match any entry, so they fall into the error case.
  assign err_d = rsp_valid_i && !(|rsp_hit);

  always_comb begin
    ent_d       = ent_q;
    live_hit    = 1'b0;
    fwd_tid     = '0;
    fwd_payload = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (rsp_hit[i]) begin
        // Response wins over a simultaneous flush for the entry it retires.
        if (!ent_q[i].killed) begin
          live_hit    = 1'b1;
          fwd_tid     = TID_WIDTH'(i);
          fwd_payload = ent_q[i].payload;
        end
        ent_d[i].occ    = 1'b0;
        ent_d[i].killed = 1'b0;
      end else if (flush_i && ent_q[i].occ) begin
        ent_d[i].killed = 1'b1;
      end
      // Grants only target entries free in ent_q, so this never collides with a hit.
      if (alloc_fire && (grant_tid == TID_WIDTH'(i))) begin
        ent_d[i].occ     = 1'b1;
        ent_d[i].killed  = 1'b0;
        ent_d[i].payload = alloc_payload_i;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      cnt = cnt + CNT_W'(ent_q[i].occ);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_tid_q     <= '0;
      rsp_payload_q <= '0;
      err_q         <= 1'b0;
    end else begin
      ent_q       <= ent_d;
      rsp_valid_q <= live_hit;
      err_q       <= err_d;
      if (live_hit) begin
        rsp_tid_q     <= fwd_tid;
        rsp_payload_q <= fwd_payload;
      end
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_tid_o     = rsp_tid_q;
  assign rsp_payload_o = rsp_payload_q;
  assign err_o         = err_q;
  assign count_o       = cnt;
  assign empty_o       = (cnt == '0);

`ifdef LOAD_TID_KILL_STATS_EN
  logic        kill_hit;
  logic [15:0] kill_cnt_q;

  always_comb begin
    kill_hit = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (rsp_hit[i] && ent_q[i].killed) kill_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kill_cnt_q <= '0;
    end else if (kill_hit && (kill_cnt_q != 16'hFFFF)) begin
      kill_cnt_q <= kill_cnt_q + 16'd1;
    end
  end

  assign kill_cnt_o = kill_cnt_q;
`else
  assign kill_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_load_tid_tracker.sv
module tb_load_tid_tracker;
  localparam int NR = 2;
  localparam int TW = 2;
  localparam int PW = 8;
  localparam int CW = $clog2(NR + 1);
`ifdef LOAD_TID_KILL_STATS_EN
  localparam int KS = 1;
`else
  localparam int KS = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          alloc_valid_i;
  logic          alloc_ready_o;
  logic [PW-1:0] alloc_payload_i;
  logic [TW-1:0] alloc_tid_o;
  logic          rsp_valid_i;
  logic [TW-1:0] rsp_tid_i;
  logic          flush_i;
  logic          rsp_valid_o;
  logic [TW-1:0] rsp_tid_o;
  logic [PW-1:0] rsp_payload_o;
  logic          err_o;
  logic          empty_o;
  logic [CW-1:0] count_o;
  logic [15:0]   kill_cnt_o;

  always #5 clk_i = ~clk_i;

  load_tid_tracker #(.NR_ENTRIES(NR), .TID_WIDTH(TW), .PAYLOAD_WIDTH(PW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_payload_i(alloc_payload_i), .alloc_tid_o(alloc_tid_o),
    .rsp_valid_i(rsp_valid_i), .rsp_tid_i(rsp_tid_i), .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_tid_o(rsp_tid_o), .rsp_payload_o(rsp_payload_o),
    .err_o(err_o), .empty_o(empty_o), .count_o(count_o), .kill_cnt_o(kill_cnt_o)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: each load slot is FREE, LIVE or KILLED.
  localparam int FREE = 0, LIVE = 1, KILLED = 2;
  int            m_st [NR];
  logic [PW-1:0] m_pay[NR];
  bit            m_rv;
  int            m_rt;
  logic [PW-1:0] m_rp;
  bit            m_err;
  int            m_kc;

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_st[i]  = FREE;
      m_pay[i] = '0;
    end
    m_rv = 1'b0; m_rt = 0; m_rp = '0; m_err = 1'b0; m_kc = 0;
  endtask

  // Compare process: outputs are checked mid-cycle, then the model consumes the
  // inputs that the DUT will sample at the coming rising edge.
  always @(negedge clk_i) begin
    int  free_idx;
    int  occ;
    int  t;
    bit  e_rdy;
    if (chk_en) begin
      free_idx = -1;
      occ      = 0;
      for (int i = NR - 1; i >= 0; i--) begin
        if (m_st[i] == FREE) free_idx = i;
        else occ++;
      end
      e_rdy = (free_idx >= 0) && !flush_i;
      chk("m_alloc_ready", 32'(alloc_ready_o), 32'(e_rdy));
      if (e_rdy) chk("m_alloc_tid", 32'(alloc_tid_o), 32'(free_idx));
      chk("m_count", 32'(count_o), 32'(occ));
      chk("m_empty", 32'(empty_o), 32'(occ == 0));
      chk("m_rsp_valid", 32'(rsp_valid_o), 32'(m_rv));
      if (m_rv) begin
        chk("m_rsp_tid", 32'(rsp_tid_o), 32'(m_rt));
        chk("m_rsp_payload", 32'(rsp_payload_o), 32'(m_rp));
      end
      chk("m_err", 32'(err_o), 32'(m_err));
      chk("m_kill_cnt", 32'(kill_cnt_o), 32'(m_kc));

      if (rst_i) begin
        m_reset();
      end else begin
        m_rv  = 1'b0;
        m_err = 1'b0;
        t = int'(rsp_tid_i);
        if (rsp_valid_i) begin
          if (t < NR && m_st[t] != FREE) begin
            if (m_st[t] == LIVE) begin
              m_rv = 1'b1; m_rt = t; m_rp = m_pay[t];
            end else if (KS == 1 && m_kc < 65535) begin
              m_kc++;
            end
            m_st[t] = FREE;
          end else begin
            m_err = 1'b1;
          end
        end
        if (flush_i) begin
          for (int i = 0; i < NR; i++) begin
            // Entry retired this cycle is already FREE, so only survivors are killed.
            if (m_st[i] == LIVE && !(rsp_valid_i && t == i)) m_st[i] = KILLED;
          end
        end
        if (alloc_valid_i && e_rdy) begin
          m_st[free_idx]  = LIVE;
          m_pay[free_idx] = alloc_payload_i;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    m_reset();
    rst_i = 1'b1; alloc_valid_i = 1'b0; alloc_payload_i = '0;
    rsp_valid_i = 1'b0; rsp_tid_i = '0; flush_i = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_tid", 32'(rsp_tid_o), 32'd0);
    chk("rst_rsp_payload", 32'(rsp_payload_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_kill_cnt", 32'(kill_cnt_o), 32'd0);
    chk("rst_ready", 32'(alloc_ready_o), 32'd1);
    chk("rst_tid", 32'(alloc_tid_o), 32'd0);

    // Two allocations, then respond TID 1.
    tick(); alloc_valid_i = 1'b1; alloc_payload_i = 8'hA5;
    @(negedge clk_i); chk("a1_tid", 32'(alloc_tid_o), 32'd0);
    tick(); alloc_payload_i = 8'h3C;
    @(negedge clk_i); chk("a2_tid", 32'(alloc_tid_o), 32'd1);
    chk("a2_count", 32'(count_o), 32'd1);
    tick(); alloc_valid_i = 1'b0;
    @(negedge clk_i); chk("full_ready", 32'(alloc_ready_o), 32'd0);
    chk("full_count", 32'(count_o), 32'd2);
    tick(); rsp_valid_i = 1'b1; rsp_tid_i = 2'd1;
    tick(); rsp_valid_i = 1'b0;
    @(negedge clk_i); chk("r1_valid", 32'(rsp_valid_o), 32'd1);
    chk("r1_tid", 32'(rsp_tid_o), 32'd1);
    chk("r1_payload", 32'(rsp_payload_o), 32'h3C);

    // Response for TID 0 with a simultaneous allocation: grant goes to TID 1.
    tick(); rsp_valid_i = 1'b1; rsp_tid_i = 2'd0; alloc_valid_i = 1'b1; alloc_payload_i = 8'h77;
    @(negedge clk_i); chk("sim_tid", 32'(alloc_tid_o), 32'd1);
    tick(); rsp_valid_i = 1'b0; alloc_payload_i = 8'h55;
    @(negedge clk_i); chk("reuse_tid", 32'(alloc_tid_o), 32'd0);
    chk("sim_rsp_payload", 32'(rsp_payload_o), 32'hA5);
    tick(); alloc_valid_i = 1'b0;
    @(negedge clk_i); chk("sim_count", 32'(count_o), 32'd2);

    // Flush with two loads outstanding; both responses suppressed.
    tick(); flush_i = 1'b1;
    @(negedge clk_i); chk("flush_ready", 32'(alloc_ready_o), 32'd0);
    tick(); flush_i = 1'b0; rsp_valid_i = 1'b1; rsp_tid_i = 2'd0;
    @(negedge clk_i); chk("kill_count2", 32'(count_o), 32'd2);
    tick(); rsp_tid_i = 2'd1;
    @(negedge clk_i); chk("kill_count1", 32'(count_o), 32'd1);
    chk("kill_rv0", 32'(rsp_valid_o), 32'd0);
    tick(); rsp_valid_i = 1'b0;
    @(negedge clk_i); chk("kill_count0", 32'(count_o), 32'd0);
    chk("kill_rv1", 32'(rsp_valid_o), 32'd0);
    chk("kill_cnt2", 32'(kill_cnt_o), (KS == 1) ? 32'd2 : 32'd0);

    // Response for TID 0 coincides with flush.
    tick(); alloc_valid_i = 1'b1; alloc_payload_i = 8'h99;
    tick(); alloc_payload_i = 8'h66;
    tick(); alloc_valid_i = 1'b0;
    @(negedge clk_i); chk("rf_count", 32'(count_o), 32'd2);
    tick(); rsp_valid_i = 1'b1; rsp_tid_i = 2'd0; flush_i = 1'b1;
    tick(); flush_i = 1'b0; rsp_tid_i = 2'd1;
    @(negedge clk_i); chk("rf_valid", 32'(rsp_valid_o), 32'd1);
    chk("rf_tid", 32'(rsp_tid_o), 32'd0);
    chk("rf_payload", 32'(rsp_payload_o), 32'h99);
    tick(); rsp_valid_i = 1'b0;
    @(negedge clk_i); chk("rf_supp", 32'(rsp_valid_o), 32'd0);
    chk("rf_count0", 32'(count_o), 32'd0);
    chk("rf_kill_cnt", 32'(kill_cnt_o), (KS == 1) ? 32'd3 : 32'd0);

    // Bad TIDs: FREE entry 1 and out-of-range 3.
    tick(); alloc_valid_i = 1'b1; alloc_payload_i = 8'h12;
    tick(); alloc_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_tid_i = 2'd1;
    tick(); rsp_tid_i = 2'd3;
    @(negedge clk_i); chk("err_free", 32'(err_o), 32'd1);
    chk("err_free_count", 32'(count_o), 32'd1);
    tick(); rsp_valid_i = 1'b0;
    @(negedge clk_i); chk("err_range", 32'(err_o), 32'd1);
    chk("err_range_count", 32'(count_o), 32'd1);
    tick();
    @(negedge clk_i); chk("err_clear", 32'(err_o), 32'd0);

    // Reset with both entries LIVE, then a stale response.
    tick(); alloc_valid_i = 1'b1; alloc_payload_i = 8'h34;
    tick(); alloc_valid_i = 1'b0;
    @(negedge clk_i); chk("pre_rst_count", 32'(count_o), 32'd2);
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    @(negedge clk_i); chk("mid_rst_empty", 32'(empty_o), 32'd1);
    chk("mid_rst_ready", 32'(alloc_ready_o), 32'd1);
    chk("mid_rst_tid", 32'(alloc_tid_o), 32'd0);
    tick(); rsp_valid_i = 1'b1; rsp_tid_i = 2'd0;
    tick(); rsp_valid_i = 1'b0;
    @(negedge clk_i); chk("stale_err", 32'(err_o), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_i           = ($urandom_range(0, 299) == 0);
      flush_i         = ($urandom_range(0, 15) == 0);
      alloc_valid_i   = 1'($urandom_range(0, 1));
      alloc_payload_i = PW'($urandom);
      rsp_valid_i     = ($urandom_range(0, 2) != 0);
      rsp_tid_i       = ($urandom_range(0, 5) == 0) ? TW'($urandom_range(0, 3))
                                                    : TW'($urandom_range(0, NR - 1));
    end
    tick();
    rst_i = 1'b0; flush_i = 1'b0; alloc_valid_i = 1'b0; rsp_valid_i = 1'b0;
    tick();
    tick();
    @(negedge clk_i);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
